// File: rtl/effect_sample_reader.sv
// Captures samples from an upstream effect block via a valid/ack handshake into a
// small FIFO, and drains one sample per audio tick toward the DAC path.
module effect_sample_reader #(
  parameter int data_width = 16,
  parameter int fifo_depth = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [data_width-1:0]         i_data,
  input  logic                          i_data_valid,
  output logic                          o_read_done,
  input  logic                          i_sample_tick,
  output logic [data_width-1:0]         o_sample,
  output logic                          o_sample_strobe,
  output logic [$clog2(fifo_depth):0]   o_fifo_level,
  output logic                          o_underrun,
  output logic [7:0]                    o_underrun_count
);

  localparam int AW = $clog2(fifo_depth);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(fifo_depth);

  typedef enum logic [1:0] {
    WAIT_VALID,
    ACK,
    WAIT_RELEASE
  } state_t;

  state_t                state;
  logic [data_width-1:0] mem [fifo_depth];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_en;
  logic                  rd_en;

  // Both decisions use the occupancy before this edge, so a tick on an empty
  // FIFO is an underrun even when a write lands on the same edge.
  always_comb begin
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (state == WAIT_VALID && i_data_valid && o_fifo_level != DEPTH_L)
      wr_en = 1'b1;
    if (i_sample_tick && o_fifo_level != '0)
      rd_en = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= WAIT_VALID;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      o_fifo_level     <= '0;
      o_sample         <= '0;
      o_read_done      <= 1'b0;
      o_sample_strobe  <= 1'b0;
      o_underrun       <= 1'b0;
      o_underrun_count <= '0;
    end else begin
      case (state)
        WAIT_VALID:   if (wr_en) state <= ACK;
        ACK:          state <= WAIT_RELEASE;
        WAIT_RELEASE: if (!i_data_valid) state <= WAIT_VALID;
        default:      state <= WAIT_VALID;
      endcase

      o_read_done <= wr_en;

      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr   <= rd_ptr + 1'b1;
        o_sample <= mem[rd_ptr];
      end

      case ({wr_en, rd_en})
        2'b10:   o_fifo_level <= o_fifo_level + 1'b1;
        2'b01:   o_fifo_level <= o_fifo_level - 1'b1;
        default: o_fifo_level <= o_fifo_level;
      endcase

      o_sample_strobe <= i_sample_tick;
      o_underrun      <= i_sample_tick && o_fifo_level == '0;
      if (i_sample_tick && o_fifo_level == '0 && o_underrun_count != '1)
        o_underrun_count <= o_underrun_count + 1'b1;
    end
  end

endmodule
